// File: rtl/reg_writeback_if.sv
// Bundle between the MEM stage, the long-latency unit and the register-file write port.
// The write-back block is the slave; the pipeline/testbench side is the master.
interface reg_writeback_if;
  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_mem_to_reg;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [1:0]  mem_load_size;
  logic        mem_load_unsigned;
  logic [1:0]  mem_addr_lo;

  // lu handshake: a result transfers on a rising edge where lu_valid & lu_ready are both 1.
  // lu_valid must not wait on lu_ready; lu_ready depends only on registered state.
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;

  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        stall_req;
  logic        init_busy;
  logic        dbg_state;

  modport master (
    output mem_valid, mem_reg_write, mem_mem_to_reg, mem_rd, mem_alu_result,
           mem_load_data, mem_load_size, mem_load_unsigned, mem_addr_lo,
           lu_valid, lu_rd, lu_data,
    input  lu_ready, reg_write, rd, write_data, stall_req, init_busy, dbg_state
  );

  modport slave (
    input  mem_valid, mem_reg_write, mem_mem_to_reg, mem_rd, mem_alu_result,
           mem_load_data, mem_load_size, mem_load_unsigned, mem_addr_lo,
           lu_valid, lu_rd, lu_data,
    output lu_ready, reg_write, rd, write_data, stall_req, init_busy, dbg_state
  );
endinterface

// File: rtl/reg_writeback.sv
// Write-back stage: owns the register-file write port, formats loads, arbitrates
// pipeline writes against long-latency completions, and zero-sweeps the file after reset.
module reg_writeback (
  input  logic            clk,
  input  logic            rst_n,
  reg_writeback_if.slave  bus
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_sweep;
  logic [4:0]  w_sweep_nxt;

  logic [4:0]  r_q_rd   [2];
  logic [31:0] r_q_data [2];
  logic [1:0]  r_q_cnt;

  logic        r_reg_write;
  logic [4:0]  r_rd;
  logic [31:0] r_wdata;

  logic        w_lu_ready;
  logic        w_pw;
  logic        w_lw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_pipe_data;
  logic        w_wr_en;
  logic [4:0]  w_wr_rd;
  logic [31:0] w_wr_data;
  logic        w_push;
  logic        w_pop;

  assign w_lu_ready = (r_state == S_RUN) && (r_q_cnt != 2'd2);
  assign w_pw = bus.mem_valid && bus.mem_reg_write && (bus.mem_rd != 5'd0);
  // A zero-destination lu handshake still completes, it just never reaches the queue.
  assign w_lw = bus.lu_valid && w_lu_ready && (bus.lu_rd != 5'd0);

  always_comb begin
    w_byte = bus.mem_load_data[7:0];
    case (bus.mem_addr_lo)
      2'd1:    w_byte = bus.mem_load_data[15:8];
      2'd2:    w_byte = bus.mem_load_data[23:16];
      2'd3:    w_byte = bus.mem_load_data[31:24];
      default: w_byte = bus.mem_load_data[7:0];
    endcase
    w_half = bus.mem_addr_lo[1] ? bus.mem_load_data[31:16] : bus.mem_load_data[15:0];
    case (bus.mem_load_size)
      2'b10:   w_load = {{24{~bus.mem_load_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~bus.mem_load_unsigned & w_half[15]}}, w_half};
      default: w_load = bus.mem_load_data;
    endcase
    w_pipe_data = bus.mem_mem_to_reg ? w_load : bus.mem_alu_result;
  end

  // Next state, write-port selection and queue control. Pipeline writes always win.
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_wr_en     = 1'b0;
    w_wr_rd     = r_rd;
    w_wr_data   = r_wdata;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_INIT: begin
        w_wr_en     = 1'b1;
        w_wr_rd     = r_sweep;
        w_wr_data   = 32'd0;
        w_sweep_nxt = r_sweep + 5'd1;
        if (r_sweep == 5'd31) w_state_nxt = S_RUN;
      end
      default: begin
        if (w_pw) begin
          w_wr_en   = 1'b1;
          w_wr_rd   = bus.mem_rd;
          w_wr_data = w_pipe_data;
          w_push    = w_lw;
        end else if (r_q_cnt != 2'd0) begin
          w_wr_en   = 1'b1;
          w_wr_rd   = r_q_rd[0];
          w_wr_data = r_q_data[0];
          w_pop     = 1'b1;
          w_push    = w_lw;
        end else if (w_lw) begin
          w_wr_en   = 1'b1;
          w_wr_rd   = bus.lu_rd;
          w_wr_data = bus.lu_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_sweep     <= 5'd0;
      r_q_cnt     <= 2'd0;
      r_reg_write <= 1'b0;
      r_rd        <= 5'd0;
      r_wdata     <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep     <= w_sweep_nxt;
      r_reg_write <= w_wr_en;
      r_rd        <= w_wr_rd;
      r_wdata     <= w_wr_data;
      case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 2'd1;
        2'b01:   r_q_cnt <= r_q_cnt - 2'd1;
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  // Entry 0 is always the head; storage needs no reset because the count gates it.
  always_ff @(posedge clk) begin
    case ({w_push, w_pop})
      2'b10: begin
        if (r_q_cnt == 2'd0) begin
          r_q_rd[0]   <= bus.lu_rd;
          r_q_data[0] <= bus.lu_data;
        end else begin
          r_q_rd[1]   <= bus.lu_rd;
          r_q_data[1] <= bus.lu_data;
        end
      end
      2'b01: begin
        r_q_rd[0]   <= r_q_rd[1];
        r_q_data[0] <= r_q_data[1];
      end
      2'b11: begin
        if (r_q_cnt == 2'd1) begin
          r_q_rd[0]   <= bus.lu_rd;
          r_q_data[0] <= bus.lu_data;
        end else begin
          r_q_rd[0]   <= r_q_rd[1];
          r_q_data[0] <= r_q_data[1];
          r_q_rd[1]   <= bus.lu_rd;
          r_q_data[1] <= bus.lu_data;
        end
      end
      default: ;
    endcase
  end

  assign bus.lu_ready   = w_lu_ready;
  assign bus.reg_write  = r_reg_write;
  assign bus.rd         = r_rd;
  assign bus.write_data = r_wdata;
  assign bus.stall_req  = (r_state == S_INIT) || (r_q_cnt == 2'd2);
  assign bus.init_busy  = (r_state == S_INIT);
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: reset sweep, load formatting, arbitration,
// queue-full backpressure, zero-register suppression and mid-operation reset.
module tb_reg_writeback;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [37:0] exp_q[$];

  reg_writeback_if bus ();

  reg_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lo;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab[8] = '{
    '{2'b10, 1'b0, 2'd0, 32'hFFFF_FFA5},
    '{2'b10, 1'b1, 2'd1, 32'h0000_00F0},
    '{2'b01, 1'b0, 2'd2, 32'hFFFF_8000},
    '{2'b00, 1'b0, 2'd0, 32'h8000_F0A5},
    '{2'b11, 1'b1, 2'd3, 32'h8000_F0A5},
    '{2'b01, 1'b1, 2'd3, 32'h0000_8000},
    '{2'b01, 1'b0, 2'd0, 32'hFFFF_F0A5},
    '{2'b10, 1'b0, 2'd3, 32'hFFFF_FF80}
  };

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.mem_valid         = 1'b0;
    bus.mem_reg_write     = 1'b0;
    bus.mem_mem_to_reg    = 1'b0;
    bus.mem_rd            = 5'd0;
    bus.mem_alu_result    = 32'd0;
    bus.mem_load_data     = 32'd0;
    bus.mem_load_size     = 2'b00;
    bus.mem_load_unsigned = 1'b0;
    bus.mem_addr_lo       = 2'd0;
    bus.lu_valid          = 1'b0;
    bus.lu_rd             = 5'd0;
    bus.lu_data           = 32'd0;
  endtask

  task automatic set_pipe(input logic [4:0] rd, input logic m2r, input logic [31:0] alu,
                          input logic [31:0] ld, input logic [1:0] size, input logic uns,
                          input logic [1:0] lo);
    bus.mem_valid         = 1'b1;
    bus.mem_reg_write     = 1'b1;
    bus.mem_rd            = rd;
    bus.mem_mem_to_reg    = m2r;
    bus.mem_alu_result    = alu;
    bus.mem_load_data     = ld;
    bus.mem_load_size     = size;
    bus.mem_load_unsigned = uns;
    bus.mem_addr_lo       = lo;
  endtask

  task automatic bubble();
    bus.mem_valid = 1'b0;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.lu_valid = v;
    bus.lu_rd    = rd;
    bus.lu_data  = data;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] erd, input logic [31:0] edata);
    check({tag, "_wr"}, {2'b0, bus.reg_write, bus.rd, bus.write_data}, {2'b0, 1'b1, erd, edata});
  endtask

  // scoreboard: pops the next expected write and compares the port against it
  task automatic check_next_wr(input string tag);
    logic [37:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 40'd1, 40'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {2'b0, bus.reg_write, bus.rd, bus.write_data}, {2'b0, e});
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    clr_inputs();

    // Reset with garbage inputs that the sweep must ignore.
    set_pipe(5'd9, 1'b0, 32'hDEAD_BEEF, 32'd0, 2'b00, 1'b0, 2'd0);
    set_lu(1'b1, 5'd13, 32'h0000_BEEF);
    tick();
    tick();
    check("rst_we",    {39'd0, bus.reg_write}, 40'd0);
    check("rst_rd",    {35'd0, bus.rd}, 40'd0);
    check("rst_data",  {8'd0, bus.write_data}, 40'd0);
    check("rst_busy",  {39'd0, bus.init_busy}, 40'd1);
    check("rst_ready", {39'd0, bus.lu_ready}, 40'd0);
    check("rst_stall", {39'd0, bus.stall_req}, 40'd1);

    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check_wr("sweep", 5'(i), 32'd0);
      check("sweep_busy", {39'd0, bus.init_busy}, (i == 31) ? 40'd0 : 40'd1);
    end
    clr_inputs();
    tick();
    check("idle_we",    {39'd0, bus.reg_write}, 40'd0);
    check("idle_ready", {39'd0, bus.lu_ready}, 40'd1);
    check("idle_stall", {39'd0, bus.stall_req}, 40'd0);

    // Load formatting on 0x8000_F0A5; the ALU value differs so a mux fault shows.
    for (int i = 0; i < 8; i++) begin
      set_pipe(5'd5, 1'b1, 32'h5555_5555, 32'h8000_F0A5, ld_tab[i].size, ld_tab[i].uns, ld_tab[i].lo);
      tick();
      check_wr($sformatf("load%0d", i), 5'd5, ld_tab[i].exp);
    end
    set_pipe(5'd6, 1'b0, 32'h5555_5555, 32'h8000_F0A5, 2'b10, 1'b0, 2'd0);
    tick();
    check_wr("alu_sel", 5'd6, 32'h5555_5555);

    // Arbitration: pipeline wins, lu result follows the next cycle from the queue.
    set_pipe(5'd3, 1'b0, 32'h0000_0033, 32'd0, 2'b00, 1'b0, 2'd0);
    set_lu(1'b1, 5'd7, 32'h0000_1234);
    tick();
    check_wr("arb_first", 5'd3, 32'h0000_0033);
    check("arb_ready", {39'd0, bus.lu_ready}, 40'd1);
    clr_inputs();
    tick();
    check_wr("arb_second", 5'd7, 32'h0000_1234);
    tick();
    check("arb_idle", {39'd0, bus.reg_write}, 40'd0);

    // Queue full: pipeline writes every cycle while lu offers 8, 9, 10.
    exp_q.push_back({1'b1, 5'd1,  32'h0000_00A0});
    exp_q.push_back({1'b1, 5'd2,  32'h0000_00A1});
    exp_q.push_back({1'b1, 5'd3,  32'h0000_00A2});
    exp_q.push_back({1'b1, 5'd8,  32'h0000_0088});
    exp_q.push_back({1'b1, 5'd9,  32'h0000_0099});
    exp_q.push_back({1'b1, 5'd10, 32'h0000_00AA});
    set_pipe(5'd1, 1'b0, 32'h0000_00A0, 32'd0, 2'b00, 1'b0, 2'd0);
    set_lu(1'b1, 5'd8, 32'h0000_0088);
    tick();
    check_next_wr("qf_w1");
    check("qf_ready1", {39'd0, bus.lu_ready}, 40'd1);
    set_pipe(5'd2, 1'b0, 32'h0000_00A1, 32'd0, 2'b00, 1'b0, 2'd0);
    set_lu(1'b1, 5'd9, 32'h0000_0099);
    tick();
    check_next_wr("qf_w2");
    check("qf_ready_full", {39'd0, bus.lu_ready}, 40'd0);
    check("qf_stall_full", {39'd0, bus.stall_req}, 40'd1);
    set_pipe(5'd3, 1'b0, 32'h0000_00A2, 32'd0, 2'b00, 1'b0, 2'd0);
    set_lu(1'b1, 5'd10, 32'h0000_00AA);
    tick();
    check_next_wr("qf_w3");
    check("qf_ready_held", {39'd0, bus.lu_ready}, 40'd0);
    bubble();
    tick();
    check_next_wr("qf_pop8");
    check("qf_ready_back", {39'd0, bus.lu_ready}, 40'd1);
    check("qf_stall_low",  {39'd0, bus.stall_req}, 40'd0);
    tick();
    check_next_wr("qf_pop9");
    clr_inputs();
    check("qf_ready_one", {39'd0, bus.lu_ready}, 40'd1);
    tick();
    check_next_wr("qf_pop10");
    tick();
    check("qf_idle_we",   {39'd0, bus.reg_write}, 40'd0);
    check("qf_hold_rd",   {35'd0, bus.rd}, 40'd10);
    check("qf_hold_data", {8'd0, bus.write_data}, 40'h00AA);

    // Zero-register suppression on both sources.
    set_pipe(5'd0, 1'b0, 32'h0000_0077, 32'd0, 2'b00, 1'b0, 2'd0);
    tick();
    check("zero_pw_we", {39'd0, bus.reg_write}, 40'd0);
    clr_inputs();
    set_lu(1'b1, 5'd0, 32'h0000_0066);
    check("zero_lu_ready", {39'd0, bus.lu_ready}, 40'd1);
    tick();
    check("zero_lw_we", {39'd0, bus.reg_write}, 40'd0);
    clr_inputs();
    tick();
    check("zero_after_we",    {39'd0, bus.reg_write}, 40'd0);
    check("zero_after_ready", {39'd0, bus.lu_ready}, 40'd1);
    check("zero_after_stall", {39'd0, bus.stall_req}, 40'd0);

    // Mid-operation reset with a full queue.
    set_pipe(5'd4, 1'b0, 32'h0000_00C4, 32'd0, 2'b00, 1'b0, 2'd0);
    set_lu(1'b1, 5'd11, 32'h0000_00B1);
    tick();
    set_pipe(5'd6, 1'b0, 32'h0000_00C6, 32'd0, 2'b00, 1'b0, 2'd0);
    set_lu(1'b1, 5'd12, 32'h0000_00B2);
    tick();
    check("mr_full_stall", {39'd0, bus.stall_req}, 40'd1);
    clr_inputs();
    rst_n = 1'b0;
    tick();
    check("mr_we",    {39'd0, bus.reg_write}, 40'd0);
    check("mr_rd",    {35'd0, bus.rd}, 40'd0);
    check("mr_busy",  {39'd0, bus.init_busy}, 40'd1);
    check("mr_ready", {39'd0, bus.lu_ready}, 40'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check_wr("mr_sweep", 5'(i), 32'd0);
    end
    tick();
    check("mr_dropped_we", {39'd0, bus.reg_write}, 40'd0);
    check("mr_ready_run",  {39'd0, bus.lu_ready}, 40'd1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage and sole owner of the register file's single write port. Each cycle it takes the MEM-stage result, formats load data, and arbitrates the write port against completions from the long-latency unit (mul/div). Completions that lose arbitration wait in a 2-entry queue. After reset it clears every register with a zero sweep. Its registered write-port outputs also feed the decode-stage forwarding logic.

## Interface
Parameters:
- none; the queue depth is fixed at 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mem_valid  in  1  MEM-stage slot holds a real instruction.
- mem_reg_write  in  1  instruction writes a register.
- mem_mem_to_reg  in  1  1 selects formatted load data, 0 selects the ALU result.
- mem_rd  in  5  destination register.
- mem_alu_result  in  32  ALU result.
- mem_load_data  in  32  raw memory word.
- mem_load_size  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- mem_load_unsigned  in  1  1 zero-extends, 0 sign-extends.
- mem_addr_lo  in  2  byte address bits [1:0].
- lu_valid  in  1  long-latency unit offers a result.
- lu_ready  out  1  block accepts the offered result.
- lu_rd  in  5  result destination.
- lu_data  in  32  result value.
- reg_write  out  1  register-file write enable, registered.
- rd  out  5  register-file write address, registered.
- write_data  out  32  register-file write data, registered.
- stall_req  out  1  requests a pipeline bubble (hazard unit forces mem_valid=0).
- init_busy  out  1  zero sweep in progress.

## Operation
- States: INIT and RUN.
- INIT:
  - A 5-bit sweep counter c drives reg_write=1, rd=c, write_data=0, then increments.
  - When c=31 is issued, the state moves to RUN.
  - All mem_* and lu_* inputs are ignored; lu_ready=0.
- RUN, pipeline write request: pw = mem_valid & mem_reg_write & (mem_rd != 0).
- Pipeline data:
  - mem_mem_to_reg=0: mem_alu_result.
  - Otherwise, formatted load data:
    - Byte: lane mem_addr_lo (bits 8*a+7:8*a).
    - Half: mem_addr_lo[1]=0 gives bits 15:0, 1 gives bits 31:16; mem_addr_lo[0] is ignored.
    - Word: unchanged.
    - Byte and half are extended to 32 bits per mem_load_unsigned.
- Long-latency request: lw = lu_valid & lu_ready & (lu_rd != 0). A handshake with lu_rd=0 is accepted and discarded.
- Arbitration at each RUN edge, highest priority first:
  1. pw: issue the pipeline write. If lw, enqueue the lu result.
  2. Queue non-empty: issue the head and pop. If lw in the same cycle, enqueue (push and pop together; count unchanged).
  3. lw: issue the lu result directly; the queue is bypassed.
  4. None: reg_write=0; rd and write_data hold their values.
- Queue: 2-entry FIFO of {rd, data}; entries are issued in arrival order.
- lu_ready = (state==RUN) & (count<2); combinational from the registered count.
- stall_req = (state==INIT) | (count==2).
- init_busy = (state==INIT).
- rd=0 is never written in RUN, so register 0 holds the 0 written during the sweep.

## Timing
- Reset (rst_n=0 at an edge):
  - state=INIT, c=0, queue empty.
  - reg_write=0, rd=0, write_data=0.
  - From that edge: lu_ready=0, stall_req=1, init_busy=1.
- Reset asserted mid-operation: queued entries are dropped and the sweep restarts at c=0.
- Sweep: edges 1..32 after rst_n rises issue rd=0..31 with data 0. Edge 32 enters RUN, so init_busy=0 and lu_ready=1 from then on.
- Latency: inputs sampled at edge k appear on the write port during cycle k..k+1; the register file commits at edge k+1.
- Forwarding sees the registered outputs during the same cycle.
- Write-port throughput: one write per cycle.
- Queue-full boundary: when count reaches 2, lu_ready drops combinationally and stall_req rises.
  - The next bubble (pw=0) pops one entry; lu_ready returns the following cycle.
- lu results are never lost or reordered. A pipeline write is never delayed.

## Test plan
- Reset then idle:
  - rst_n low for 2 cycles, then high.
  - Required: 32 writes rd=0..31, data 0, one per cycle. init_busy falls after the rd=31 write. reg_write=0 afterwards.
- Load formatting:
  - mem_load_data=0x8000_F0A5, mem_mem_to_reg=1, rd=5.
  - Required results:
    - Signed byte, addr_lo=0: 0xFFFF_FFA5.
    - Unsigned byte, addr_lo=1: 0x0000_00F0.
    - Signed half, addr_lo=2: 0xFFFF_8000.
    - Word: 0x8000_F0A5.
- Arbitration:
  - pw (rd=3) and lw (rd=7, 0x1234) in the same cycle, then pw=0.
  - Required: rd=3 written first, then rd=7 with 0x1234 the next cycle.
- Queue full:
  - pw every cycle; lu offers rd=8,9,10.
  - Required: after 8 and 9 are accepted, lu_ready=0 and stall_req=1.
  - After one bubble: rd=8 written, lu_ready=1. After a second bubble: 9 written. Then 10 accepted.
- Zero-register suppression: pw with mem_rd=0, and lw with lu_rd=0 → reg_write stays 0, queue count stays 0.
- Mid-operation reset: queue holding 2 entries, rst_n pulsed low → queue discarded and the sweep restarts at rd=0.
